epochtv1_vram_arb: RTL



---
 rtl/epochtv1_vram_arb.sv | 112 +++++++++++
 1 files changed

// File: rtl/epochtv1_vram_arb.sv
// VRAM slot arbiter (render fetch vs CPU): one access per CE slot, ACK/VALID the slot after grant.
// Define EPOCHTV1_VRAM_ARB_STATS_EN to add the CPU_STALLS counter and STATS_CLR input.
module epochtv1_vram_arb #(
  parameter int CPU_MAX_WAIT = 4,
  parameter int AW           = 12
) (
  input  logic          CLK,
  input  logic          RESB,
  input  logic          CE,
  input  logic          FETCH,
  input  logic          RREQ,
  input  logic [AW-1:0] RA,
  output logic [7:0]    RD,
  output logic          RVALID,
  input  logic          CREQ,
  input  logic          CWE,
  input  logic [AW-1:0] CA,
  input  logic [7:0]    CDI,
  output logic [7:0]    CDO,
  output logic          CACK,
  output logic [10:0]   VA,
  input  logic [7:0]    VD_I,
  output logic [7:0]    VD_O,
  output logic          nVWE,
  output logic [1:0]    nVCS
`ifdef EPOCHTV1_VRAM_ARB_STATS_EN
  ,
  input  logic          STATS_CLR,
  output logic [15:0]   CPU_STALLS
`endif
);

  typedef enum logic [1:0] {IDLE, RACC, CRD, CWR} state_t;

  localparam logic [3:0] MAX_WAIT = 4'(CPU_MAX_WAIT);

  state_t        state_q, state_d;
  logic [3:0]    wait_q, wait_d;
  logic [AW-1:0] addr_d;
  logic          cpu_busy, cpu_elig, rnd_elig;

  // A requester finishing in the current slot still holds its request at this
  // edge; mask it so it is not granted a duplicate. During FETCH a held RREQ
  // is a continuous fetch stream, so render stays eligible back-to-back.
  assign cpu_busy = (state_q == CRD) || (state_q == CWR);
  assign cpu_elig = CREQ && !cpu_busy;
  assign rnd_elig = RREQ && !((state_q == RACC) && !FETCH);

  always_comb begin
    state_d = IDLE;
    wait_d  = wait_q;
    addr_d  = '0;
    if (cpu_elig && ((wait_q >= MAX_WAIT) || !(FETCH && RREQ))) begin
      state_d = CWE ? CWR : CRD;
      wait_d  = '0;
      addr_d  = CA;
    end else if (rnd_elig) begin
      state_d = RACC;
      addr_d  = RA;
      if (CREQ) wait_d = (wait_q == 4'hF) ? wait_q : 4'(wait_q + 4'd1);
      else      wait_d = '0;
    end else if (!CREQ) begin
      wait_d = '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESB) begin
      state_q <= IDLE;
      wait_q  <= '0;
      nVCS    <= 2'b11;
      nVWE    <= 1'b1;
      VA      <= '0;
      VD_O    <= '0;
      RD      <= '0;
      CDO     <= '0;
      RVALID  <= 1'b0;
      CACK    <= 1'b0;
    end else if (CE) begin
      state_q <= state_d;
      wait_q  <= wait_d;
      RVALID  <= (state_q == RACC);
      CACK    <= cpu_busy;
      if (state_q == RACC) RD  <= VD_I;
      if (state_q == CRD)  CDO <= VD_I;
      VA   <= 11'(addr_d[AW-2:0]);
      nVCS <= (state_d == IDLE) ? 2'b11 : (addr_d[AW-1] ? 2'b01 : 2'b10);
      nVWE <= (state_d != CWR);
      VD_O <= (state_d == CWR) ? CDI : 8'h00;
    end
  end

`ifdef EPOCHTV1_VRAM_ARB_STATS_EN
  logic [15:0] stalls_q;

  always_ff @(posedge CLK) begin
    if (!RESB) begin
      stalls_q <= '0;
    end else if (CE) begin
      if (STATS_CLR)
        stalls_q <= '0;
      else if ((state_d == RACC) && CREQ && (stalls_q != 16'hFFFF))
        stalls_q <= stalls_q + 16'd1;
    end
  end

  assign CPU_STALLS = stalls_q;
`else
  // stall accounting compiled out
`endif

endmodule
